// File: rtl/inst_buffer_if.sv
// Fetch-to-decode bundle interface for inst_buffer.
// master = fetch/decode side driving bundles and ready; slave = the buffer.
interface inst_buffer_if #(
    parameter int unsigned PIPE_WIDTH    = 2,
    parameter int unsigned CPU_ADDR_BITS = 32,
    parameter int unsigned CPU_INST_BITS = 32
);
    logic                                      if_val;
    logic [PIPE_WIDTH-1:0]                     if_mask;
    logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0]  if_pcs;
    logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0]  if_insts;
    logic                                      ibuf_rdy;
    logic                                      decode_rdy;
    logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0]  inst_pcs;
    logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0]  insts;
    logic                                      fetch_val;

    modport master (
        output if_val, if_mask, if_pcs, if_insts, decode_rdy,
        input  ibuf_rdy, inst_pcs, insts, fetch_val
    );

    modport slave (
        input  if_val, if_mask, if_pcs, if_insts, decode_rdy,
        output ibuf_rdy, inst_pcs, insts, fetch_val
    );
endinterface

// File: rtl/inst_buffer.sv
// Two-wide compacting instruction FIFO between fetch and decode (show-ahead).
// Optional same-cycle bypass when empty: define IBUF_BYPASS_EN.
module inst_buffer #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned PIPE_WIDTH    = 2,
    parameter int unsigned CPU_ADDR_BITS = 32,
    parameter int unsigned CPU_INST_BITS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    inst_buffer_if.slave   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    typedef logic [PW:0]              ptr_t;
    typedef logic [PW-1:0]            idx_t;
    typedef logic [CPU_ADDR_BITS-1:0] pc_t;
    typedef logic [CPU_INST_BITS-1:0] inst_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam pc_t  PC_STEP = pc_t'(4);

    pc_t   pc_mem   [DEPTH];
    inst_t inst_mem [DEPTH];

    ptr_t  head, tail, count, free_slots, n_enq, n_deq;
    idx_t  head_idx, head_nxt_idx, tail_idx, tail_nxt_idx;
    logic  rdy, s_val, s_two, wr, deq, bypass, byp_take;

    pc_t   c_pc0, c_pc1;
    inst_t c_inst0, c_inst1;

    assign count        = tail - head;
    assign free_slots   = DEPTH_P - count;
    assign rdy          = (free_slots >= ptr_t'(2));
    assign head_idx     = head[PW-1:0];
    assign head_nxt_idx = head_idx + idx_t'(1);
    assign tail_idx     = tail[PW-1:0];
    assign tail_nxt_idx = tail_idx + idx_t'(1);
    assign s_val        = (count != '0);
    assign s_two        = (count >= ptr_t'(2));

    // A lone valid slot (mask 01 or 10) is shifted down into slot 0.
    always_comb begin
        c_pc0   = bus.if_mask[0] ? bus.if_pcs[0]   : bus.if_pcs[1];
        c_inst0 = bus.if_mask[0] ? bus.if_insts[0] : bus.if_insts[1];
        c_pc1   = (bus.if_mask == 2'b11) ? bus.if_pcs[1]   : c_pc0 + PC_STEP;
        c_inst1 = (bus.if_mask == 2'b11) ? bus.if_insts[1] : '0;
    end

`ifdef IBUF_BYPASS_EN
    assign bypass = (count == '0) && !flush;
`else
    assign bypass = 1'b0;
`endif
    assign byp_take = bypass && bus.decode_rdy;

    assign wr    = bus.if_val && rdy && !flush && !byp_take;
    assign n_enq = wr ? (ptr_t'(bus.if_mask[0]) + ptr_t'(bus.if_mask[1])) : '0;
    assign deq   = bus.decode_rdy && s_val;
    assign n_deq = !deq ? '0 : (s_two ? ptr_t'(2) : ptr_t'(1));

    assign bus.ibuf_rdy = rdy;

    always_comb begin
        bus.fetch_val   = 1'b0;
        bus.inst_pcs    = '0;
        bus.insts       = '0;
        if (bypass) begin
            if (bus.if_val && (bus.if_mask != '0)) begin
                bus.fetch_val   = 1'b1;
                bus.inst_pcs[0] = c_pc0;
                bus.insts[0]    = c_inst0;
                bus.inst_pcs[1] = c_pc1;
                bus.insts[1]    = c_inst1;
            end
        end else if (s_val) begin
            bus.fetch_val   = 1'b1;
            bus.inst_pcs[0] = pc_mem[head_idx];
            bus.insts[0]    = inst_mem[head_idx];
            bus.inst_pcs[1] = s_two ? pc_mem[head_nxt_idx] : pc_mem[head_idx] + PC_STEP;
            bus.insts[1]    = s_two ? inst_mem[head_nxt_idx] : '0;
        end
    end

    // Storage is not reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (wr && (bus.if_mask != '0)) begin
            pc_mem[tail_idx]   <= c_pc0;
            inst_mem[tail_idx] <= c_inst0;
            if (bus.if_mask == 2'b11) begin
                pc_mem[tail_nxt_idx]   <= bus.if_pcs[1];
                inst_mem[tail_nxt_idx] <= bus.if_insts[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + n_deq;
            tail <= tail + n_enq;
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (DEPTH=8).
module tb_inst_buffer;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst_n;
    logic flush;
    int   total;
    int   bad;

    inst_buffer_if #(.PIPE_WIDTH(2), .CPU_ADDR_BITS(32), .CPU_INST_BITS(32)) bus ();

    inst_buffer #(
        .DEPTH(DEPTH), .PIPE_WIDTH(2), .CPU_ADDR_BITS(32), .CPU_INST_BITS(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[23:0], 8'h13};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] mask, input logic [31:0] pc0, input logic [31:0] pc1);
        bus.if_val      = 1'b1;
        bus.if_mask     = mask;
        bus.if_pcs[0]   = pc0;
        bus.if_pcs[1]   = pc1;
        bus.if_insts[0] = inst_of(pc0);
        bus.if_insts[1] = inst_of(pc1);
    endtask

    task automatic idle();
        bus.if_val   = 1'b0;
        bus.if_mask  = '0;
        bus.if_pcs   = '0;
        bus.if_insts = '0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.decode_rdy = 1'b0;
        idle();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_pair(input string tag, input logic [31:0] pc0, input logic [31:0] pc1);
        check({tag, "_val"},  bus.fetch_val,   1);
        check({tag, "_pc0"},  bus.inst_pcs[0], pc0);
        check({tag, "_pc1"},  bus.inst_pcs[1], pc1);
        check({tag, "_ins0"}, bus.insts[0],    inst_of(pc0));
        check({tag, "_ins1"}, bus.insts[1],    inst_of(pc1));
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_val"}, bus.fetch_val, 0);
        check({tag, "_pcs"}, bus.inst_pcs,  0);
        check({tag, "_ins"}, bus.insts,     0);
        check({tag, "_rdy"}, bus.ibuf_rdy,  1);
    endtask

    initial begin
        int model_cnt, sent, rcv, cycles, take;
        logic [31:0] exp_pc;
        total = 0;
        bad   = 0;

        // reset state
        do_reset();
        #2;
        check_empty("reset");

        // fill with decode stalled, overrun, then drain in pairs
        for (int b = 0; b < 4; b++) begin
            drive(2'b11, 32'(8 * b), 32'(8 * b + 4));
            #2;
            check($sformatf("fill_rdy%0d", b), bus.ibuf_rdy, 1);
            if (b > 0) check_pair($sformatf("fill_hold%0d", b), 32'h0, 32'h4);
            tick();
        end
        drive(2'b11, 32'h20, 32'h24);
        #2;
        check("full_rdy", bus.ibuf_rdy, 0);
        tick();
        idle();
        bus.decode_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            check_pair($sformatf("drain%0d", k), 32'(8 * k), 32'(8 * k + 4));
            if (k == 1) check("drain_rdy6", bus.ibuf_rdy, 1);
            tick();
        end
        #2;
        check_empty("drained");
        bus.decode_rdy = 1'b0;

        // compaction of 01 / 11 / 10 / 00 masks
        drive(2'b01, 32'h300, 32'hBAD0); tick();
        drive(2'b11, 32'h304, 32'h308);  tick();
        drive(2'b10, 32'hBAD4, 32'h30C); tick();
        drive(2'b00, 32'h999, 32'h999);  tick();
        idle();
        bus.decode_rdy = 1'b1;
        #2; check_pair("cmp_a", 32'h300, 32'h304); tick();
        #2; check_pair("cmp_b", 32'h308, 32'h30C); tick();
        #2; check_empty("cmp_end");
        bus.decode_rdy = 1'b0;

        // single mask-10 bundle: slot1 padded with pc0+4 / inst 0
        drive(2'b10, 32'hBAD8, 32'h104);
        bus.if_insts[1] = 32'h00500093;
        tick();
        idle();
        #2;
        check("one_val",  bus.fetch_val,   1);
        check("one_pc0",  bus.inst_pcs[0], 32'h104);
        check("one_ins0", bus.insts[0],    32'h00500093);
        check("one_pc1",  bus.inst_pcs[1], 32'h108);
        check("one_ins1", bus.insts[1],    0);
        bus.decode_rdy = 1'b1;
        tick();
        #2;
        check_empty("one_end");
        bus.decode_rdy = 1'b0;

        // flush with 5 held plus a same-cycle bundle
        drive(2'b11, 32'h400, 32'h404); tick();
        drive(2'b11, 32'h408, 32'h40C); tick();
        drive(2'b01, 32'h410, 32'hBADC); tick();
        drive(2'b11, 32'h500, 32'h504);
        flush          = 1'b1;
        bus.decode_rdy = 1'b1;
        #2;
        check("pre_flush_rdy", bus.ibuf_rdy, 1);
        tick();
        flush          = 1'b0;
        bus.decode_rdy = 1'b0;
        idle();
        #2;
        check_empty("flush");
        drive(2'b11, 32'h600, 32'h604); tick();
        idle();
        #2;
        check_pair("post_flush", 32'h600, 32'h604);

        // streaming with random decode stalls; model tracks occupancy
        do_reset();
        model_cnt = 0; sent = 0; rcv = 0; cycles = 0;
        exp_pc = 32'h1000;
        while (rcv < 40 && cycles < 400) begin
            if (sent < 20) drive(2'b11, 32'h1000 + 32'(8 * sent), 32'h1004 + 32'(8 * sent));
            else idle();
            bus.decode_rdy = 1'($urandom_range(0, 1));
            #2;
            check("st_rdy", bus.ibuf_rdy, (model_cnt <= DEPTH - 2) ? 1 : 0);
            check("st_val", bus.fetch_val, (model_cnt != 0) ? 1 : 0);
            take = 0;
            if (bus.decode_rdy && model_cnt != 0) begin
                check("st_pc0",  bus.inst_pcs[0], exp_pc);
                check("st_ins0", bus.insts[0],    inst_of(exp_pc));
                exp_pc += 4; take = 1;
                if (model_cnt >= 2) begin
                    check("st_pc1", bus.inst_pcs[1], exp_pc);
                    exp_pc += 4; take = 2;
                end else begin
                    check("st_ins1_pad", bus.insts[1], 0);
                end
            end
            rcv += take;
            model_cnt -= take;
            if (sent < 20 && (model_cnt + take) <= DEPTH - 2) begin
                model_cnt += 2;
                sent++;
            end
            cycles++;
            tick();
        end
        check("st_rcv", 64'(rcv), 40);
        idle();
        bus.decode_rdy = 1'b0;

        // async reset mid-cycle with 4 held
        do_reset();
        drive(2'b11, 32'h700, 32'h704); tick();
        drive(2'b11, 32'h708, 32'h70C); tick();
        idle();
        #2;
        check("ar_before", bus.fetch_val, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_empty("ar");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // empty-buffer latency / bypass
        bus.decode_rdy = 1'b1;
        drive(2'b11, 32'h200, 32'h204);
        #2;
`ifdef IBUF_BYPASS_EN
        check_pair("byp", 32'h200, 32'h204);
        tick();
        idle();
        #2;
        check_empty("byp_after");
`else
        check("lat_same", bus.fetch_val, 0);
        tick();
        idle();
        bus.decode_rdy = 1'b0;
        #2;
        check_pair("lat_next", 32'h200, 32'h204);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
